// File: rtl/uart_tx_scheduler.sv
// Arbitrates ALU-result and register-file requests onto a single UART transmitter,
// presenting one byte at a time through the transmitter's data-valid/busy handshake.
module uart_tx_scheduler #(
   parameter int unsigned DW  = 8,
   parameter int unsigned TMO = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            alu_req,
   input  logic [2*DW-1:0] alu_data,
   output logic            alu_ack,
   input  logic            rf_req,
   input  logic [DW-1:0]   rf_data,
   output logic            rf_ack,
   input  logic            tx_busy,
   output logic [DW-1:0]   tx_p_data,
   output logic            tx_d_vld,
   output logic            sched_busy,
   output logic            tmo_err
);

   localparam int unsigned SW = 2 * DW;
   localparam int unsigned TW = 4;
   localparam int unsigned BW = 2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_PULSE   = 3'd2;
   localparam logic [2:0] S_WAIT_HI = 3'd3;
   localparam logic [2:0] S_WAIT_LO = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic          r_ptr_rf;
   logic          w_ptr_rf_nxt;
   logic [SW-1:0] r_shreg;
   logic [SW-1:0] w_shreg_nxt;
   logic [BW-1:0] r_bcnt;
   logic [BW-1:0] w_bcnt_nxt;
   logic [BW-1:0] w_bcnt_dec;
   logic [TW-1:0] r_tmo_cnt;
   logic [TW-1:0] w_tmo_cnt_nxt;
   logic [TW-1:0] w_tmo_inc;
   logic [DW-1:0] w_p_data_nxt;
   logic          w_alu_ack_nxt;
   logic          w_rf_ack_nxt;
   logic          w_tmo_err_nxt;
   logic          w_both_req;
   logic          w_grant_alu;
   logic          w_grant_rf;

   // Round-robin only matters when both sides ask at once; the pointer names the winner.
   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_rf  = 1'b0;
      w_both_req  = alu_req & rf_req;
      if (r_state == S_IDLE) begin
         if (w_both_req) begin
            w_grant_alu = ~r_ptr_rf;
            w_grant_rf  = r_ptr_rf;
         end else begin
            w_grant_alu = alu_req;
            w_grant_rf  = rf_req;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_rf_nxt  = r_ptr_rf;
      w_shreg_nxt   = r_shreg;
      w_bcnt_nxt    = r_bcnt;
      w_tmo_cnt_nxt = r_tmo_cnt;
      w_p_data_nxt  = tx_p_data;
      w_tmo_err_nxt = tmo_err;
      w_alu_ack_nxt = 1'b0;
      w_rf_ack_nxt  = 1'b0;
      w_bcnt_dec    = r_bcnt - BW'(1);
      w_tmo_inc     = r_tmo_cnt + TW'(1);

      case (r_state)
         S_IDLE: begin
            if (w_grant_alu) begin
               w_shreg_nxt   = alu_data;
               w_bcnt_nxt    = BW'(2);
               w_alu_ack_nxt = 1'b1;
               w_state_nxt   = S_LOAD;
               if (w_both_req) w_ptr_rf_nxt = 1'b1;
            end else if (w_grant_rf) begin
               w_shreg_nxt   = SW'(rf_data);
               w_bcnt_nxt    = BW'(1);
               w_rf_ack_nxt  = 1'b1;
               w_state_nxt   = S_LOAD;
               if (w_both_req) w_ptr_rf_nxt = 1'b0;
            end
         end
         S_LOAD: begin
            w_p_data_nxt = r_shreg[DW-1:0];
            w_state_nxt  = S_PULSE;
         end
         S_PULSE: begin
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               w_state_nxt = S_WAIT_LO;
            end else begin
               w_tmo_cnt_nxt = w_tmo_inc;
               // Transmitter never acknowledged the byte: drop the rest of this request.
               if (w_tmo_inc == TW'(TMO)) begin
                  w_tmo_err_nxt = 1'b1;
                  w_bcnt_nxt    = '0;
                  w_state_nxt   = S_IDLE;
               end
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               w_shreg_nxt = r_shreg >> DW;
               w_bcnt_nxt  = w_bcnt_dec;
               w_state_nxt = (w_bcnt_dec == '0) ? S_IDLE : S_LOAD;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; tx_d_vld/sched_busy follow the state being entered.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_ptr_rf   <= 1'b0;
         r_shreg    <= '0;
         r_bcnt     <= '0;
         r_tmo_cnt  <= '0;
         alu_ack    <= 1'b0;
         rf_ack     <= 1'b0;
         tx_p_data  <= '0;
         tx_d_vld   <= 1'b0;
         sched_busy <= 1'b0;
         tmo_err    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr_rf   <= w_ptr_rf_nxt;
         r_shreg    <= w_shreg_nxt;
         r_bcnt     <= w_bcnt_nxt;
         r_tmo_cnt  <= w_tmo_cnt_nxt;
         alu_ack    <= w_alu_ack_nxt;
         rf_ack     <= w_rf_ack_nxt;
         tx_p_data  <= w_p_data_nxt;
         tx_d_vld   <= (w_state_nxt == S_PULSE);
         sched_busy <= (w_state_nxt != S_IDLE);
         tmo_err    <= w_tmo_err_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester and transmitter-busy models,
// expected acks/bytes queued at stimulus time and popped as the DUT emits them.
module tb_uart_tx_scheduler;

   localparam int unsigned DW       = 8;
   localparam int unsigned TMO      = 4;
   localparam int          BUSY_LEN = 20;

   logic            CLK = 1'b0;
   logic            RST;
   logic            alu_req;
   logic [2*DW-1:0] alu_data;
   logic            alu_ack;
   logic            rf_req;
   logic [DW-1:0]   rf_data;
   logic            rf_ack;
   logic            tx_busy;
   logic [DW-1:0]   tx_p_data;
   logic            tx_d_vld;
   logic            sched_busy;
   logic            tmo_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit busy_en;
   bit busy_pend;
   int busy_hold;
   int vld_count;
   int ack_count;
   int last_vld_cyc;
   int falls[$];
   logic [2*DW-1:0] alu_vals[$];
   logic [DW-1:0]   rf_vals[$];
   logic [DW-1:0]   exp_bytes[$];
   bit              exp_ack[$];
   bit sb_hist[int];
   bit vld_hist[int];
   bit tmo_hist[int];

   uart_tx_scheduler #(.DW(DW), .TMO(TMO)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .alu_req    (alu_req),
      .alu_data   (alu_data),
      .alu_ack    (alu_ack),
      .rf_req     (rf_req),
      .rf_data    (rf_data),
      .rf_ack     (rf_ack),
      .tx_busy    (tx_busy),
      .tx_p_data  (tx_p_data),
      .tx_d_vld   (tx_d_vld),
      .sched_busy (sched_busy),
      .tmo_err    (tmo_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: sample at negedge, score outputs, then advance requester and busy models.
   task automatic tick();
      @(negedge CLK);
      cyc++;
      sb_hist[cyc]  = sched_busy;
      vld_hist[cyc] = tx_d_vld;
      tmo_hist[cyc] = tmo_err;
      if (alu_ack || rf_ack) begin
         ack_count++;
         check("ack_exclusive", 32'(alu_ack & rf_ack), 32'd0);
         if (exp_ack.size() == 0) check("ack_unexpected", 32'({alu_ack, rf_ack}), 32'd0);
         else check("ack_side", 32'({alu_ack, rf_ack}), exp_ack.pop_front() ? 32'd1 : 32'd2);
      end
      if (alu_ack && alu_vals.size() > 0) alu_vals.delete(0);
      if (rf_ack && rf_vals.size() > 0) rf_vals.delete(0);
      alu_req = (alu_vals.size() > 0);
      if (alu_vals.size() > 0) alu_data = alu_vals[0];
      rf_req = (rf_vals.size() > 0);
      if (rf_vals.size() > 0) rf_data = rf_vals[0];
      if (busy_hold > 0) begin
         busy_hold--;
         if (busy_hold == 0) begin
            tx_busy = 1'b0;
            falls.push_back(cyc);
         end
      end
      if (busy_pend) begin
         busy_pend = 1'b0;
         tx_busy   = 1'b1;
         busy_hold = BUSY_LEN;
      end
      if (tx_d_vld) begin
         vld_count++;
         last_vld_cyc = cyc;
         if (exp_bytes.size() == 0) check("vld_unexpected", 32'(tx_d_vld), 32'd0);
         else check("tx_byte", 32'(tx_p_data), 32'(exp_bytes.pop_front()));
         if (busy_en) busy_pend = 1'b1;
      end
   endtask

   task automatic push_alu(input logic [2*DW-1:0] v);
      alu_vals.push_back(v);
      alu_req  = 1'b1;
      alu_data = alu_vals[0];
   endtask

   task automatic push_rf(input logic [DW-1:0] v);
      rf_vals.push_back(v);
      rf_req  = 1'b1;
      rf_data = rf_vals[0];
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (n < budget && !(exp_ack.size() == 0 && exp_bytes.size() == 0 && !sched_busy
                 && !busy_pend && busy_hold == 0 && alu_vals.size() == 0 && rf_vals.size() == 0));
      check({tag, "_drained"}, 32'(exp_ack.size() + exp_bytes.size()), 32'd0);
      check({tag, "_idle"}, 32'(sched_busy), 32'd0);
   endtask

   task automatic wait_busy_high(input string tag);
      int n = 0;
      while (!tx_busy && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_busy_seen"}, 32'(tx_busy), 32'd1);
   endtask

   task automatic apply_reset();
      RST       = 1'b0;
      alu_vals.delete();
      rf_vals.delete();
      alu_req   = 1'b0;
      rf_req    = 1'b0;
      tx_busy   = 1'b0;
      busy_pend = 1'b0;
      busy_hold = 0;
      tick();
      tick();
      RST = 1'b1;
   endtask

   initial begin
      int vbase;
      int abase;
      RST = 1'b0; alu_req = 1'b0; alu_data = '0; rf_req = 1'b0; rf_data = '0; tx_busy = 1'b0;
      busy_en = 1'b0; busy_pend = 1'b0; busy_hold = 0;
      vld_count = 0; ack_count = 0; last_vld_cyc = 0;

      tick();
      tick();
      check("rst_alu_ack", 32'(alu_ack), 32'd0);
      check("rst_rf_ack", 32'(rf_ack), 32'd0);
      check("rst_tx_p_data", 32'(tx_p_data), 32'd0);
      check("rst_tx_d_vld", 32'(tx_d_vld), 32'd0);
      check("rst_sched_busy", 32'(sched_busy), 32'd0);
      check("rst_tmo_err", 32'(tmo_err), 32'd0);
      RST = 1'b1;
      tick();

      // Single RF byte
      busy_en = 1'b1; falls.delete(); vbase = vld_count; abase = ack_count;
      exp_ack.push_back(1'b1); exp_bytes.push_back(8'hA5);
      push_rf(8'hA5);
      run_until_done("rf_only", 200);
      check("rf_only_vld_count", 32'(vld_count - vbase), 32'd1);
      check("rf_only_ack_count", 32'(ack_count - abase), 32'd1);
      check("rf_only_falls", 32'(falls.size()), 32'd1);
      if (falls.size() > 0) begin
         check("rf_only_sb_at_fall", 32'(sb_hist[falls[0]]), 32'd1);
         check("rf_only_sb_after_fall", 32'(sb_hist[falls[0] + 1]), 32'd0);
      end

      // Two-byte ALU word, LSB first
      falls.delete(); vbase = vld_count; abase = ack_count;
      exp_ack.push_back(1'b0); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
      push_alu(16'h1234);
      run_until_done("alu_two", 300);
      check("alu_two_vld_count", 32'(vld_count - vbase), 32'd2);
      check("alu_two_falls", 32'(falls.size()), 32'd2);
      if (falls.size() > 0) begin
         check("alu_two_no_early_pulse", 32'(vld_hist[falls[0] + 1]), 32'd0);
         check("alu_two_second_pulse", 32'(vld_hist[falls[0] + 2]), 32'd1);
         check("alu_two_sb_between", 32'(sb_hist[falls[0] + 1]), 32'd1);
      end

      // Simultaneous requests from reset: ALU, RF, ALU, RF
      apply_reset();
      vbase = vld_count; abase = ack_count;
      exp_ack.push_back(1'b0); exp_ack.push_back(1'b1); exp_ack.push_back(1'b0); exp_ack.push_back(1'b1);
      exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'hBE); exp_bytes.push_back(8'h11);
      exp_bytes.push_back(8'hFE); exp_bytes.push_back(8'hCA); exp_bytes.push_back(8'h22);
      push_alu(16'hBEEF); push_alu(16'hCAFE);
      push_rf(8'h11); push_rf(8'h22);
      run_until_done("rr", 1000);
      check("rr_ack_count", 32'(ack_count - abase), 32'd4);
      check("rr_vld_count", 32'(vld_count - vbase), 32'd6);

      // Busy never rises: timeout, sticky error, later request still served
      busy_en = 1'b0; tx_busy = 1'b0;
      exp_ack.push_back(1'b1); exp_bytes.push_back(8'h5A);
      push_rf(8'h5A);
      run_until_done("tmo", 100);
      check("tmo_err_before", 32'(tmo_hist[last_vld_cyc + int'(TMO)]), 32'd0);
      check("tmo_err_at", 32'(tmo_hist[last_vld_cyc + int'(TMO) + 1]), 32'd1);
      check("tmo_sb_before", 32'(sb_hist[last_vld_cyc + int'(TMO)]), 32'd1);
      check("tmo_sb_idle", 32'(sb_hist[last_vld_cyc + int'(TMO) + 1]), 32'd0);
      repeat (5) tick();
      check("tmo_err_sticky", 32'(tmo_err), 32'd1);
      busy_en = 1'b1; abase = ack_count;
      exp_ack.push_back(1'b1); exp_bytes.push_back(8'h3C);
      push_rf(8'h3C);
      run_until_done("tmo_after", 200);
      check("tmo_after_ack", 32'(ack_count - abase), 32'd1);
      check("tmo_err_still", 32'(tmo_err), 32'd1);

      // Reset during WAIT_LO of the first ALU byte
      exp_ack.push_back(1'b0); exp_bytes.push_back(8'h66);
      push_alu(16'h5566);
      wait_busy_high("mid");
      repeat (5) tick();
      check("mid_in_transfer", 32'(sched_busy), 32'd1);
      #2 RST = 1'b0;
      #1;
      check("mid_rst_alu_ack", 32'(alu_ack), 32'd0);
      check("mid_rst_rf_ack", 32'(rf_ack), 32'd0);
      check("mid_rst_tx_d_vld", 32'(tx_d_vld), 32'd0);
      check("mid_rst_tx_p_data", 32'(tx_p_data), 32'd0);
      check("mid_rst_sched_busy", 32'(sched_busy), 32'd0);
      check("mid_rst_tmo_err", 32'(tmo_err), 32'd0);
      alu_vals.delete(); alu_req = 1'b0; tx_busy = 1'b0; busy_hold = 0; busy_pend = 1'b0;
      tick();
      RST = 1'b1;
      vbase = vld_count;
      repeat (30) tick();
      check("mid_no_vld_after", 32'(vld_count - vbase), 32'd0);
      check("mid_idle_after", 32'(sched_busy), 32'd0);
      check("mid_drained", 32'(exp_ack.size() + exp_bytes.size()), 32'd0);

      // RF request withdrawn while an ALU transfer is in WAIT_LO
      vbase = vld_count; abase = ack_count;
      exp_ack.push_back(1'b0); exp_bytes.push_back(8'h88); exp_bytes.push_back(8'h77);
      push_alu(16'h7788);
      wait_busy_high("wd");
      repeat (3) tick();
      push_rf(8'h99);
      repeat (3) tick();
      rf_vals.delete(); rf_req = 1'b0;
      run_until_done("wd", 300);
      check("wd_vld_count", 32'(vld_count - vbase), 32'd2);
      check("wd_ack_count", 32'(ack_count - abase), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequencer and arbiter in front of the UART transmitter, in the UART clock domain.
- Shares the transmitter between two requesters:
  - ALU-result path: 2*DW-bit word, sent as two bytes, LSB byte first.
  - Register-file read path: single DW-bit byte.
- Arbitrates between the two, captures the payload, and drives the transmitter's one-cycle data-valid handshake.
- Tracks the transmitter's registered busy flag so a new byte is only presented when the transmitter will accept it.

Parameters:
- DW, 8, UART data byte width.
- TMO, 4, max cycles to wait for tx_busy to rise after a data-valid pulse before flagging an error (range 2..15).

Ports:
- CLK  in  1  UART-domain clock.
- RST  in  1  asynchronous active-low reset.
- alu_req  in  1  level request; held until alu_ack.
- alu_data  in  2*DW  ALU result; sampled only in the grant cycle.
- alu_ack  out  1  one-cycle pulse, ALU request accepted.
- rf_req  in  1  level request; held until rf_ack.
- rf_data  in  DW  register-file read data; sampled in the grant cycle.
- rf_ack  out  1  one-cycle pulse, RF request accepted.
- tx_busy  in  1  registered busy from the UART transmitter.
- tx_p_data  out  DW  byte to transmitter.
- tx_d_vld  out  1  one-cycle data-valid to transmitter.
- sched_busy  out  1  high whenever the FSM is not in IDLE.
- tmo_err  out  1  sticky; set on busy-rise timeout, cleared only by reset.

Behaviour:
- Reset (RST low, asynchronous):
  - FSM goes to IDLE; priority pointer points to ALU.
  - All outputs 0, tx_p_data 0, internal byte counter and timeout counter 0.
- All outputs are registered.
- States: IDLE, LOAD, PULSE, WAIT_HI, WAIT_LO.
- IDLE:
  - Grant decision:
    - Only one request high: grant it.
    - Both high: grant the side the pointer names; the pointer then toggles to the other side (round-robin).
  - On grant, in the same edge:
    - capture payload into an internal 2*DW shift register (RF byte zero-extended);
    - set byte count (2 for ALU, 1 for RF);
    - pulse the matching ack for exactly one cycle in the following cycle;
    - go to LOAD.
  - No request: stay in IDLE.
- LOAD:
  - tx_p_data <= low DW bits of the shift register; go to PULSE.
- PULSE:
  - tx_d_vld = 1 for exactly this one cycle; tx_p_data held stable.
  - Clear the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - tx_p_data held stable; wait for tx_busy = 1, then go to WAIT_LO.
  - Timeout counter increments each cycle. When it reaches TMO with tx_busy still 0:
    - set tmo_err;
    - abandon remaining bytes of this request;
    - return to IDLE.
- WAIT_LO:
  - Wait for tx_busy = 0.
  - On that cycle: shift register right by DW and decrement byte count.
    - Count becomes 0: go to IDLE.
    - Otherwise: go to LOAD.
- The transmitter's stop-state back-to-back path is deliberately not used. One idle bit-time gap between bytes is acceptable.
- A request that drops before its ack is ignored. A new request arriving during a transfer waits; it is never lost while held.
- Acks are never asserted outside the cycle after a grant; both acks are never high together.
- sched_busy is high in every state except IDLE, including the LOAD/PULSE of the second ALU byte.
- tx_busy high while the FSM is in IDLE is ignored (no state change).
- Reset mid-transfer: immediate return to IDLE, tx_d_vld deasserts asynchronously, the pending payload is discarded, and requesters must re-request.

Test Plan:
- RF only:
  - Stimulus: rf_req = 1, rf_data = 0xA5; tx_busy model rises 1 cycle after tx_d_vld and falls 20 cycles later.
  - Required: rf_ack pulses once; one tx_d_vld pulse with tx_p_data = 0xA5; sched_busy returns to 0 one cycle after tx_busy falls.
- ALU two-byte:
  - Stimulus: alu_req = 1, alu_data = 0x1234.
  - Required: tx_d_vld pulses twice, tx_p_data = 0x34 then 0x12; second pulse exactly 2 cycles after tx_busy falls (WAIT_LO -> LOAD -> PULSE).
- Simultaneous requests from reset:
  - Stimulus: alu_req = 1 and rf_req = 1; both re-request after their acks.
  - Required order: ALU, RF, ALU, RF; never two acks in the same cycle.
- Timeout:
  - Stimulus: tx_busy tied 0, rf_req = 1.
  - Required: tmo_err sets TMO cycles after the PULSE cycle and stays set; FSM returns to IDLE; a following rf_req is still served.
- Reset mid-transfer:
  - Stimulus: assert RST during WAIT_LO of the first ALU byte.
  - Required: all outputs 0 immediately; after release no tx_d_vld until a new request.
- Request withdrawn:
  - Stimulus: rf_req pulses while the FSM is in WAIT_LO of another transfer, then drops before returning to IDLE.
  - Required: no rf_ack and no extra tx_d_vld.
